// File: rtl/vga_timing_dither_if.sv
// Raster coordinate / colour bundle between the VGA timing stage and a renderer core.
interface vga_timing_dither_if #(
    parameter int unsigned IN_W  = 6,
    parameter int unsigned OUT_W = 2
) ();
    logic             enable;
    logic [1:0]       dither_mode;
    logic [10:0]      px_x;
    logic [9:0]       px_y;
    logic             px_active;
    logic [7:0]       frame_num;
    logic             frame_start;
    logic [IN_W-1:0]  r_in;
    logic [IN_W-1:0]  g_in;
    logic [IN_W-1:0]  b_in;
    logic             hsync;
    logic             vsync;
    logic [OUT_W-1:0] r_out;
    logic [OUT_W-1:0] g_out;
    logic [OUT_W-1:0] b_out;

    // master: pixel-clock top level / renderer side
    modport master (
        output enable, dither_mode, r_in, g_in, b_in,
        input  px_x, px_y, px_active, frame_num, frame_start,
        input  hsync, vsync, r_out, g_out, b_out
    );

    // slave: the timing + dither stage
    modport slave (
        input  enable, dither_mode, r_in, g_in, b_in,
        output px_x, px_y, px_active, frame_num, frame_start,
        output hsync, vsync, r_out, g_out, b_out
    );
endinterface

// File: rtl/vga_timing_dither.sv
// VGA raster timing generator with renderer latency re-alignment and ordered/temporal
// dithering of the returned colour down to DAC width.
module vga_timing_dither #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33,
    parameter int unsigned IN_W     = 6,
    parameter int unsigned OUT_W    = 2,
    parameter int unsigned PIPE_LAT = 2,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input logic                clk,
    input logic                rst_n,
    vga_timing_dither_if.slave vif
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FRONT;
    localparam int unsigned HS_END  = HS_BEG + H_SYNC;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FRONT;
    localparam int unsigned VS_END  = VS_BEG + V_SYNC;
    localparam int unsigned S       = IN_W - OUT_W;
    localparam int unsigned THR_SHL = (S >= 4) ? S - 4 : 0;
    localparam int unsigned THR_SHR = (S >= 4) ? 0 : 4 - S;
    localparam int unsigned SUM_W   = IN_W + 1;
    localparam int unsigned Q_W     = OUT_W + 1;

    localparam logic [1:0] MODE_TRUNC    = 2'd0;
    localparam logic [1:0] MODE_TEMPORAL = 2'd2;

    // Per-pixel side information that travels alongside the renderer latency
    typedef struct packed {
        logic       active;
        logic       hs;
        logic       vs;
        logic [1:0] x;
        logic [1:0] y;
        logic       f0;
    } tag_t;

    logic [10:0]      x_q;
    logic [10:0]      x_nxt;
    logic [9:0]       y_q;
    logic [9:0]       y_nxt;
    logic [7:0]       frame_q;
    logic [7:0]       frame_nxt;
    logic             active_q;
    logic             fstart_q;
    logic [1:0]       mode_q;
    logic             hs_raw;
    logic             vs_raw;
    tag_t             tag_s0;
    tag_t             tag_out;
    logic [1:0]       x_lut;
    logic [3:0]       bayer_val;
    logic [SUM_W-1:0] thr;
    logic [OUT_W-1:0] r_q;
    logic [OUT_W-1:0] g_q;
    logic [OUT_W-1:0] b_q;
    logic             hsync_q;
    logic             vsync_q;

    function automatic logic [3:0] bayer4(input logic [1:0] yy, input logic [1:0] xx);
        logic [3:0] b;
        case ({yy, xx})
            4'h0: b = 4'd0;   4'h1: b = 4'd8;   4'h2: b = 4'd2;   4'h3: b = 4'd10;
            4'h4: b = 4'd12;  4'h5: b = 4'd4;   4'h6: b = 4'd14;  4'h7: b = 4'd6;
            4'h8: b = 4'd3;   4'h9: b = 4'd11;  4'hA: b = 4'd1;   4'hB: b = 4'd9;
            4'hC: b = 4'd15;  4'hD: b = 4'd7;   4'hE: b = 4'd13;  4'hF: b = 4'd5;
            default: b = 4'd0;
        endcase
        return b;
    endfunction

    // One extra sum bit keeps c + thr from overflowing before the saturating shift
    function automatic logic [OUT_W-1:0] quant(input logic [IN_W-1:0] c,
                                              input logic [SUM_W-1:0] t);
        logic [SUM_W-1:0] sum;
        logic [Q_W-1:0]   q;
        sum = SUM_W'(c) + t;
        q   = Q_W'(sum >> S);
        return q[OUT_W] ? {OUT_W{1'b1}} : q[OUT_W-1:0];
    endfunction

    // Next raster position; frozen while enable is low
    always_comb begin
        x_nxt     = x_q;
        y_nxt     = y_q;
        frame_nxt = frame_q;
        if (vif.enable) begin
            if (x_q == 11'(H_TOTAL - 1)) begin
                x_nxt = '0;
                if (y_q == 10'(V_TOTAL - 1)) begin
                    y_nxt     = '0;
                    frame_nxt = frame_q + 8'd1;
                end else begin
                    y_nxt = y_q + 10'd1;
                end
            end else begin
                x_nxt = x_q + 11'd1;
            end
        end
    end

    // Raster state; active/frame_start flags are registered from the next position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q      <= '0;
            y_q      <= '0;
            frame_q  <= '0;
            active_q <= 1'b1;
            fstart_q <= 1'b1;
            mode_q   <= MODE_TRUNC;
        end else begin
            x_q      <= x_nxt;
            y_q      <= y_nxt;
            frame_q  <= frame_nxt;
            active_q <= (x_nxt < 11'(H_ACTIVE)) && (y_nxt < 10'(V_ACTIVE));
            fstart_q <= (x_nxt == '0) && (y_nxt == '0);
            if (fstart_q) begin
                mode_q <= vif.dither_mode;
            end
        end
    end

    assign hs_raw = (x_q >= 11'(HS_BEG)) && (x_q < 11'(HS_END));
    assign vs_raw = (y_q >= 10'(VS_BEG)) && (y_q < 10'(VS_END));

    // Stage-0 sample; a disabled raster injects blank samples so the outputs drain
    always_comb begin
        tag_s0 = '0;
        if (vif.enable) begin
            tag_s0.active = active_q;
            tag_s0.hs     = hs_raw;
            tag_s0.vs     = vs_raw;
            tag_s0.x      = x_q[1:0];
            tag_s0.y      = y_q[1:0];
            tag_s0.f0     = frame_q[0];
        end
    end

    generate
        if (PIPE_LAT == 0) begin : g_no_pipe
            assign tag_out = tag_s0;
        end else begin : g_pipe
            tag_t pipe_q [PIPE_LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < PIPE_LAT; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    pipe_q[0] <= tag_s0;
                    for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign tag_out = pipe_q[PIPE_LAT-1];
        end
    endgenerate

    // Dither threshold; temporal mode flips the column index on odd frames
    always_comb begin
        x_lut = tag_out.x;
        if (mode_q == MODE_TEMPORAL) begin
            x_lut = tag_out.x ^ {2{tag_out.f0}};
        end
        bayer_val = bayer4(tag_out.y, x_lut);
        thr       = (SUM_W'(bayer_val) << THR_SHL) >> THR_SHR;
        if (mode_q == MODE_TRUNC) begin
            thr = '0;
        end
    end

    // Registered pin stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
        end else begin
            hsync_q <= tag_out.hs ? HS_POL : ~HS_POL;
            vsync_q <= tag_out.vs ? VS_POL : ~VS_POL;
            if (tag_out.active) begin
                r_q <= quant(vif.r_in, thr);
                g_q <= quant(vif.g_in, thr);
                b_q <= quant(vif.b_in, thr);
            end else begin
                r_q <= '0;
                g_q <= '0;
                b_q <= '0;
            end
        end
    end

    assign vif.px_x        = x_q;
    assign vif.px_y        = y_q;
    assign vif.px_active   = active_q;
    assign vif.frame_num   = frame_q;
    assign vif.frame_start = fstart_q;
    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.r_out       = r_q;
    assign vif.g_out       = g_q;
    assign vif.b_out       = b_q;

endmodule
